// File: rtl/host_interface.sv
// Host-side result buffer: captures collider results per cell
// and serves registered readback of any cell over GPIO.
module host_interface #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CELLS  = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] GPIOi,
  input  logic                  collider_ready,
  input  logic                  in_collision_state,
  input  logic [DATA_WIDTH-1:0] u_x,
  input  logic [DATA_WIDTH-1:0] u_y,
  input  logic [DATA_WIDTH-1:0] rho,
  output logic [DATA_WIDTH-1:0] GPIOux,
  output logic [DATA_WIDTH-1:0] GPIOuy,
  output logic [DATA_WIDTH-1:0] GPIOrho
);

  localparam int CW = 3 * DATA_WIDTH;
  localparam int IW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_CELLS - 1);

  logic [CW-1:0]         mem [NUM_CELLS];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  in_range;
  logic                  unused_bits;

  assign wr_en    = collider_ready & in_collision_state;
  assign rd_en    = GPIOi[DATA_WIDTH-1];
  assign idx      = GPIOi[ADDR_WIDTH-1:0];
  assign in_range = 32'(idx) < 32'(NUM_CELLS);

  // Command bits between the index and read enable carry nothing.
  assign unused_bits = ^GPIOi[DATA_WIDTH-2:ADDR_WIDTH];

  // Write port: one cell per cycle, blocked while in reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr[IW-1:0]] <= {u_x, u_y, rho};
    end
  end

  // Write pointer walks the cells in order and wraps per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_WIDTH'(1);
    end
  end

  // Read port: registered, read-first; out-of-range cells give 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      {GPIOux, GPIOuy, GPIOrho} <= '0;
    end else if (rd_en) begin
      if (in_range) begin
        {GPIOux, GPIOuy, GPIOrho} <= mem[idx[IW-1:0]];
      end else begin
        {GPIOux, GPIOuy, GPIOrho} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_host_interface.sv
// Directed bench for host_interface with a 20-cell buffer so
// the wrap and out-of-range index paths are both reachable.
module tb_host_interface;

  localparam int DW = 16;
  localparam int NC = 20;
  localparam int AW = 9;

  logic          clk;
  logic          rst;
  logic [DW-1:0] gpio_i;
  logic          rdy;
  logic          coll;
  logic [DW-1:0] ux;
  logic [DW-1:0] uy;
  logic [DW-1:0] rh;
  logic [DW-1:0] o_ux;
  logic [DW-1:0] o_uy;
  logic [DW-1:0] o_rho;

  int n_checks = 0;
  int n_fail   = 0;

  host_interface #(
    .DATA_WIDTH(DW),
    .NUM_CELLS (NC),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .GPIOi             (gpio_i),
    .collider_ready    (rdy),
    .in_collision_state(coll),
    .u_x               (ux),
    .u_y               (uy),
    .rho               (rh),
    .GPIOux            (o_ux),
    .GPIOuy            (o_uy),
    .GPIOrho           (o_rho)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check3(input string tag,
                        input logic [DW-1:0] ex,
                        input logic [DW-1:0] ey,
                        input logic [DW-1:0] er);
    check({tag, ".ux"}, o_ux, ex);
    check({tag, ".uy"}, o_uy, ey);
    check({tag, ".rho"}, o_rho, er);
  endtask

  task automatic rd(input logic [DW-1:0] cmd);
    gpio_i = cmd;
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    gpio_i = '0;
    rdy    = 1'b0;
    coll   = 1'b0;
    ux     = '0;
    uy     = '0;
    rh     = '0;
    tick();
    tick();
    check3("reset", 16'h0, 16'h0, 16'h0);
    rst = 1'b0;

    // Feed cells 0..9
    for (int i = 0; i < 10; i++) begin
      rdy  = 1'b1;
      coll = 1'b1;
      ux   = 16'(i);
      uy   = 16'(2 * i);
      rh   = 16'(3 * i);
      tick();
    end
    rdy = 1'b0;
    rd(16'h8002);
    check3("feed_rd2", 16'h2, 16'h4, 16'h6);

    // Read cell 5 while writing cells 10 and 11
    rdy = 1'b1;
    ux  = 16'hAAAA;
    uy  = 16'hBBBB;
    rh  = 16'hCCCC;
    rd(16'h8005);
    check3("rd5_during_wr", 16'h5, 16'hA, 16'hF);
    tick();
    rdy = 1'b0;
    rd(16'h800A);
    check3("cell10", 16'hAAAA, 16'hBBBB, 16'hCCCC);
    rd(16'h800B);
    check3("cell11", 16'hAAAA, 16'hBBBB, 16'hCCCC);

    // Gated: ready without collision phase
    rdy  = 1'b1;
    coll = 1'b0;
    ux   = 16'h1111;
    uy   = 16'h2222;
    rh   = 16'h3333;
    gpio_i = '0;
    repeat (5) tick();
    rd(16'h8003);
    check3("gated_cell3", 16'h3, 16'h6, 16'h9);
    coll = 1'b1;
    ux   = 16'h0123;
    uy   = 16'h0456;
    rh   = 16'h0789;
    rd(16'h0000);
    rdy  = 1'b0;
    coll = 1'b0;
    rd(16'h800C);
    check3("ptr_held", 16'h0123, 16'h0456, 16'h0789);
    rd(16'h800B);
    check3("cell11_kept", 16'hAAAA, 16'hBBBB, 16'hCCCC);

    // Reset mid-feed with a read pending
    rdy  = 1'b1;
    coll = 1'b1;
    ux   = 16'hDEAD;
    uy   = 16'hBEEF;
    rh   = 16'hF00D;
    rst  = 1'b1;
    rd(16'h8003);
    check3("rst_mid", 16'h0, 16'h0, 16'h0);
    rst = 1'b0;

    // Wrap: NC+2 writes from pointer 0
    gpio_i = '0;
    for (int k = 0; k < NC + 2; k++) begin
      ux = 16'(k);
      uy = 16'(2 * k);
      rh = 16'(3 * k);
      tick();
    end
    rdy  = 1'b0;
    coll = 1'b0;
    rd(16'h8000);
    check3("wrap_cell0", 16'd20, 16'd40, 16'd60);
    rd(16'h8001);
    check3("wrap_cell1", 16'd21, 16'd42, 16'd63);
    rd(16'h8013);
    check3("last_cell", 16'd19, 16'd38, 16'd57);
    rd(16'h8002);
    check3("wrap_cell2", 16'd2, 16'd4, 16'd6);

    // Hold with read enable low
    gpio_i = 16'h0005;
    repeat (3) tick();
    check3("hold", 16'd2, 16'd4, 16'd6);

    // Middle command bits ignored
    rd(16'hFE05);
    check3("ign_bits", 16'd5, 16'd10, 16'd15);

    // Out-of-range indices
    rd(16'h8014);
    check3("oor_20", 16'h0, 16'h0, 16'h0);
    rd(16'h8002);
    check3("re_cell2", 16'd2, 16'd4, 16'd6);
    rd(16'h81FF);
    check3("oor_511", 16'h0, 16'h0, 16'h0);
    rd(16'h8002);

    // Same-cycle write and read of cell 2
    rdy  = 1'b1;
    coll = 1'b1;
    ux   = 16'h5555;
    uy   = 16'h6666;
    rh   = 16'h7777;
    rd(16'h8002);
    check3("rw_old", 16'd2, 16'd4, 16'd6);
    rdy  = 1'b0;
    coll = 1'b0;
    rd(16'h8002);
    check3("rw_new", 16'h5555, 16'h6666, 16'h7777);
    rd(16'h8003);
    check3("cell3_after", 16'd3, 16'd6, 16'd9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
